// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM (1-cycle read latency) between the fetch port and the load/store port.
// Data has priority; a streak counter forces a fetch grant after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req_i,
  input  logic [AW-1:0]     instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [DW-1:0]     instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [DW/8-1:0]   data_be_i,
  input  logic [AW-1:0]     data_addr_i,
  input  logic [DW-1:0]     data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [DW-1:0]     data_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [DW/8-1:0]   mem_be_o,
  output logic [AW-3:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic [DW-1:0]     mem_rdata_i
);

  // A zero limit still needs a 1-bit counter; it simply never leaves 0.
  localparam int unsigned   SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_INSTR,
    RESP_DATA
  } resp_t;

  resp_t         resp_q;
  logic          load_q;
  logic [SW-1:0] streak;
  logic          starve;
  logic          data_win;
  logic          instr_win;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  always_comb begin
    starve    = instr_req_i && (STARVE_LIMIT != 0) && (streak == LIMIT);
    data_win  = !rst && data_req_i && !starve;
    instr_win = !rst && instr_req_i && !data_win;
  end

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;

  always_comb begin
    mem_en_o    = data_win || instr_win;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (data_win) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i[AW-1:2];
      mem_wdata_o = data_wdata_i;
    end else if (instr_win) begin
      mem_be_o    = '1;
      mem_addr_o  = instr_addr_i[AW-1:2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q <= RESP_NONE;
      load_q <= 1'b0;
      streak <= '0;
    end else begin
      if (data_win)       resp_q <= RESP_DATA;
      else if (instr_win) resp_q <= RESP_INSTR;
      else                resp_q <= RESP_NONE;
      load_q <= data_win && !data_we_i;
      if (instr_win || !instr_req_i)
        streak <= '0;
      else if (data_win && streak != LIMIT)
        streak <= streak + 1'b1;
    end
  end

  // Responses come straight from the SRAM output; the async reset on resp_q kills them at once.
  always_comb begin
    instr_rvalid_o = (resp_q == RESP_INSTR);
    data_rvalid_o  = (resp_q == RESP_DATA);
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    data_rdata_o   = (data_rvalid_o && load_q) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, expected responses queued at grant time and
// checked by an independent monitor whenever an rvalid appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [31:0] instr_rdata, data_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        req0_i, req0_d;
  logic        gnt0_i, gnt0_d, rv0_i, rv0_d, en0, we0;
  logic [31:0] rd0_i, rd0_d, wd0;
  logic [3:0]  be0;
  logic [29:0] addr0;

  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .instr_req_i(req0_i), .instr_addr_i(instr_addr), .instr_gnt_o(gnt0_i),
    .instr_rvalid_o(rv0_i), .instr_rdata_o(rd0_i),
    .data_req_i(req0_d), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(gnt0_d), .data_rvalid_o(rv0_d),
    .data_rdata_o(rd0_d),
    .mem_en_o(en0), .mem_we_o(we0), .mem_be_o(be0), .mem_addr_o(addr0),
    .mem_wdata_o(wd0), .mem_rdata_i(32'h0)
  );

  // SRAM model: word i preloaded with 0x1000_0000+i, word 5 with 0x11223344.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[5]    <= 32'h1122_3344;
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (instr_rvalid) begin
      if (iq.size() == 0) check("instr_rvalid_unexpected", 32'd1, 32'd0);
      else                check("instr_rdata", instr_rdata, iq.pop_front());
    end else check("instr_rdata_idle", instr_rdata, 32'h0);
    if (data_rvalid) begin
      if (dq.size() == 0) check("data_rvalid_unexpected", 32'd1, 32'd0);
      else                check("data_rdata", data_rdata, dq.pop_front());
    end else check("data_rdata_idle", data_rdata, 32'h0);
  end

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                      input logic ei, input logic ed, input logic [31:0] er);
    @(posedge clk); #1;
    instr_req = ir; instr_addr = ia;
    data_req = dr; data_we = dw; data_be = be; data_addr = da; data_wdata = wd;
    @(negedge clk);
    check("instr_gnt", 32'(instr_gnt), 32'(ei));
    check("data_gnt", 32'(data_gnt), 32'(ed));
    check("mem_en", 32'(mem_en), 32'(ei | ed));
    if (ed) begin
      check("data_mem_addr", 32'(mem_addr), 32'(da[31:2]));
      check("data_mem_we", 32'(mem_we), 32'(dw));
      check("data_mem_be", 32'(mem_be), 32'(be));
      check("data_mem_wdata", mem_wdata, wd);
      dq.push_back(er);
    end else if (ei) begin
      check("fetch_mem_addr", 32'(mem_addr), 32'(ia[31:2]));
      check("fetch_mem_we", 32'(mem_we), 32'd0);
      check("fetch_mem_be", 32'(mem_be), 32'hf);
      iq.push_back(er);
    end else begin
      check("idle_mem_be", 32'(mem_be), 32'd0);
      check("idle_mem_addr", 32'(mem_addr), 32'd0);
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    int unsigned cnt_i, cnt_d;
    rst = 1'b1;
    instr_req = 1'b1; data_req = 1'b1; data_we = 1'b0; data_be = 4'hf;
    instr_addr = '0; data_addr = '0; data_wdata = '0;
    req0_i = 1'b0; req0_d = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_instr_gnt", 32'(instr_gnt), 32'd0);
    check("reset_data_gnt", 32'(data_gnt), 32'd0);
    check("reset_mem_en", 32'(mem_en), 32'd0);
    check("reset_instr_rvalid", 32'(instr_rvalid), 32'd0);
    check("reset_data_rvalid", 32'(data_rvalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; instr_req = 1'b0; data_req = 1'b0;

    // fetch-only stream
    step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1000_0000);
    step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1000_0001);
    step(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1000_0002);
    idle();

    // collision: D D D D I repeating
    pat = 10'b10000_10000;
    for (int k = 0; k < 10; k++)
      step(1'b1, 32'h20, 1'b1, 1'b0, 4'hf, 32'h24, 32'h0, pat[k], !pat[k],
           pat[k] ? 32'h1000_0008 : 32'h1000_0009);
    idle();

    // store then load same word, then byte store merge
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'hf, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hf, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h14, 32'h0000_AB00, 1'b0, 1'b1, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hf, 32'h14, 32'h0, 1'b0, 1'b1, 32'h1122_AB44);
    idle();

    // reset while a load response is on the bus
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hf; data_addr = 32'h18;
    @(negedge clk);
    check("pre_reset_load_gnt", 32'(data_gnt), 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
    check("pre_reset_rvalid", 32'(data_rvalid), 32'd1);
    rst = 1'b1; instr_req = 1'b1; instr_addr = 32'h0;
    #1;
    check("reset_drops_rvalid", 32'(data_rvalid), 32'd0);
    check("reset_drops_rdata", data_rdata, 32'h0);
    check("reset_forces_gnt", 32'(instr_gnt), 32'd0);
    check("reset_forces_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_fetch_gnt", 32'(instr_gnt), 32'd1);
    iq.push_back(32'h1000_0000);
    idle();
    idle();

    // STARVE_LIMIT=0 instance: strict data priority
    cnt_i = 0; cnt_d = 0;
    @(posedge clk); #1;
    req0_i = 1'b1; req0_d = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cnt_i += 32'(gnt0_i);
      cnt_d += 32'(gnt0_d);
      @(posedge clk);
    end
    #1;
    req0_i = 1'b0; req0_d = 1'b0;
    check("strict_data_grants", cnt_d, 32'd8);
    check("strict_instr_grants", cnt_i, 32'd0);

    idle();
    idle();
    idle();
    check("instr_queue_drained", iq.size(), 32'd0);
    check("data_queue_drained", dq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
